// File: rtl/seven_seg_top.sv
// Eight-column multiplexed seven-segment driver: money total on cols 0-2,
// candy count on col 4. Ports: clk, reset (async low), sum, candy_sum -> display_column, out.
module seven_seg_top #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sum,
  input  logic [2:0] candy_sum,
  output logic [7:0] display_column,
  output logic [7:0] out
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0] presc;
  logic [2:0]  col;
  logic        wrap;
  logic [3:0]  ones;
  logic [3:0]  tens;
  logic [3:0]  hund;
  logic [3:0]  dig;

  function automatic logic [7:0] seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign wrap = (presc == LAST);

  always_comb begin
    ones = 4'(sum % 8'd10);
    tens = 4'((sum / 8'd10) % 8'd10);
    hund = 4'(sum / 8'd100);
  end

  // Code 4'hF decodes to all segments off, used for blanked columns.
  always_comb begin
    dig = 4'hF;
    unique case (col)
      3'd0: dig = ones;
      3'd1: if (sum >= 8'd10)  dig = tens;
      3'd2: if (sum >= 8'd100) dig = hund;
      3'd4: dig = {1'b0, candy_sum};
      default: dig = 4'hF;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc          <= '0;
      col            <= '0;
      display_column <= 8'hFF;
      out            <= 8'hFF;
    end else begin
      display_column <= ~(8'd1 << col);
      out            <= seg(dig);
      if (wrap) begin
        presc <= '0;
        col   <= col + 3'd1;
      end else begin
        presc <= presc + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_top.sv
// Self-checking bench for seven_seg_top: vector table, directed corner
// sequences and randomized inputs against a frame-position reference model.
module tb_seven_seg_top;

  localparam int DIV = 4;
  localparam logic [7:0] SEG [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  logic       clk;
  logic       reset;
  logic [7:0] sum;
  logic [2:0] candy_sum;
  logic [7:0] display_column;
  logic [7:0] out;

  int vectors = 0;
  int miscompares = 0;
  int ecnt = 0;

  typedef struct {
    int         s;
    int         k;
    int         c;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [20];

  seven_seg_top #(.SCAN_DIV(DIV)) dut (
    .clk(clk),
    .reset(reset),
    .sum(sum),
    .candy_sum(candy_sum),
    .display_column(display_column),
    .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] model(int c, int s, int k);
    int d;
    d = -1;
    case (c)
      0: d = s % 10;
      1: if (s >= 10) d = (s / 10) % 10;
      2: if (s >= 100) d = s / 100;
      4: d = k;
      default: d = -1;
    endcase
    return (d < 0) ? 8'hFF : SEG[d];
  endfunction

  function automatic logic [7:0] col_mask(int c);
    logic [7:0] m;
    m = 8'h01 << c;
    return ~m;
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int next_col();
    return (ecnt / DIV) % 8;
  endfunction

  task automatic tick_check();
    int c;
    logic [7:0] eo;
    @(posedge clk);
    c  = next_col();
    eo = model(c, int'(sum), int'(candy_sum));
    ecnt++;
    #1;
    check("column", display_column, col_mask(c));
    check("segments", out, eo);
  endtask

  task automatic tick_dark();
    @(posedge clk);
    #1;
    check("dark_col", display_column, 8'hFF);
    check("dark_seg", out, 8'hFF);
  endtask

  task automatic goto_col(int c);
    int n;
    n = 0;
    while (next_col() != c && n < 8 * DIV + 2) begin
      tick_check();
      n++;
    end
  endtask

  task automatic goto_col_start(int c);
    int n;
    n = 0;
    while (!(next_col() == c && ecnt % DIV == 0) && n < 8 * DIV + 2) begin
      tick_check();
      n++;
    end
  endtask

  task automatic set_vec(int i, int s, int k, int c, logic [7:0] e);
    tbl[i].s = s; tbl[i].k = k; tbl[i].c = c; tbl[i].exp = e;
  endtask

  initial begin
    set_vec(0, 123, 5, 0, 8'hB0);
    set_vec(1, 123, 5, 1, 8'hA4);
    set_vec(2, 123, 5, 2, 8'hF9);
    set_vec(3, 123, 5, 3, 8'hFF);
    set_vec(4, 123, 5, 4, 8'h92);
    set_vec(5, 123, 5, 5, 8'hFF);
    set_vec(6, 123, 5, 6, 8'hFF);
    set_vec(7, 123, 5, 7, 8'hFF);
    set_vec(8, 7, 7, 0, 8'hF8);
    set_vec(9, 7, 7, 1, 8'hFF);
    set_vec(10, 7, 7, 2, 8'hFF);
    set_vec(11, 7, 7, 4, 8'hF8);
    set_vec(12, 255, 7, 0, 8'h92);
    set_vec(13, 255, 7, 1, 8'h92);
    set_vec(14, 255, 7, 2, 8'hA4);
    set_vec(15, 100, 0, 1, 8'hC0);
    set_vec(16, 100, 0, 2, 8'hF9);
    set_vec(17, 10, 0, 1, 8'hF9);
    set_vec(18, 10, 0, 2, 8'hFF);
    set_vec(19, 99, 0, 2, 8'hFF);

    // Reset held with live inputs, checked right at the assertion instant.
    reset = 1'b1;
    sum = 8'd88;
    candy_sum = 3'd3;
    #2;
    reset = 1'b0;
    #1;
    check("reset_async_col", display_column, 8'hFF);
    check("reset_async_seg", out, 8'hFF);
    repeat (3) tick_dark();

    // Release with zeros and run a full frame plus wrap to column 0.
    sum = 8'd0;
    candy_sum = 3'd0;
    reset = 1'b1;
    ecnt = 0;
    tick_check();
    check("first_edge_col", display_column, 8'hFE);
    check("first_edge_seg", out, 8'hC0);
    repeat (8 * DIV) tick_check();
    check("frame_wrap_col", display_column, 8'hFE);

    foreach (tbl[i]) begin
      sum = 8'(tbl[i].s);
      candy_sum = 3'(tbl[i].k);
      goto_col(tbl[i].c);
      tick_check();
      check("tbl_col", display_column, col_mask(tbl[i].c));
      check("tbl_seg", out, tbl[i].exp);
    end

    // Input change mid-dwell on column 0 shows up exactly one edge later.
    sum = 8'd9;
    goto_col_start(0);
    tick_check();
    check("dwell_before", out, 8'h90);
    sum = 8'd4;
    tick_check();
    check("dwell_after", out, 8'h99);
    check("dwell_col", display_column, 8'hFE);
    repeat (DIV - 2) tick_check();
    check("dwell_end_col", display_column, 8'hFE);
    tick_check();
    check("dwell_next_col", display_column, 8'hFD);

    // Reset mid-scan on column 5, then restart with a full col0 dwell.
    goto_col(5);
    tick_check();
    #2;
    reset = 1'b0;
    #1;
    check("midscan_rst_col", display_column, 8'hFF);
    check("midscan_rst_seg", out, 8'hFF);
    tick_dark();
    reset = 1'b1;
    ecnt = 0;
    for (int i = 0; i < DIV; i++) begin
      tick_check();
      check("restart_col0", display_column, 8'hFE);
    end
    tick_check();
    check("restart_col1", display_column, 8'hFD);

    // Randomized inputs changing on arbitrary cycles, occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) sum = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) candy_sum = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b0;
        #1;
        check("rand_rst_col", display_column, 8'hFF);
        check("rand_rst_seg", out, 8'hFF);
        tick_dark();
        reset = 1'b1;
        ecnt = 0;
      end
      tick_check();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
